// File: rtl/z80_seq_ld_extaddr_dd_if.sv
// rtl/z80_seq_ld_extaddr_dd_if.sv - memory bus owned by the LD (nn),dd sequencer
// The sequencer is the bus master; the memory system is the slave.
interface z80_seq_ld_extaddr_dd_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/z80_seq_ld_extaddr_dd.sv
// rtl/z80_seq_ld_extaddr_dd.sv - ED 43/53/63/73 LD (nn),dd execution sequencer
// Optional z80fi trace ports are enabled with Z80FI_TRACE_EN.
module z80_seq_ld_extaddr_dd (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [1:0]                   dd_i,
  input  logic [15:0]                  pc_i,
  output logic [3:0]                   reg_rnum_o,
  input  logic [15:0]                  reg_rdata_i,
  z80_seq_ld_extaddr_dd_if.master      bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  pc_o
`ifdef Z80FI_TRACE_EN
  ,
  output logic                         trace_valid_o,
  output logic [31:0]                  trace_insn_o,
  output logic [15:0]                  trace_mem_waddr_o,
  output logic [15:0]                  trace_mem_waddr2_o,
  output logic [7:0]                   trace_mem_wdata_o,
  output logic [7:0]                   trace_mem_wdata2_o,
  output logic [15:0]                  trace_pc_rdata_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_NL, S_RD_NH, S_WR_L, S_WR_H, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] nn_q, nn_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  dd_q, dd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 16'h0000;
      nn_q    <= 16'h0000;
      data_q  <= 16'h0000;
      dd_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      nn_q    <= nn_d;
      data_q  <= data_d;
      dd_q    <= dd_d;
    end
  end

  // Outputs decode state and latches only; mem_ready steers next state alone.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    nn_d          = nn_q;
    data_d        = data_q;
    dd_d          = dd_q;
    reg_rnum_o    = {2'b10, dd_q};
    bus.mem_addr  = 16'h0000;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'h00;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    pc_o          = 16'h0000;

    case (state_q)
      S_IDLE: begin
        busy_o     = 1'b0;
        reg_rnum_o = {2'b10, dd_i};
        if (start_i) begin
          pc_d    = pc_i;
          dd_d    = dd_i;
          data_d  = reg_rdata_i;
          state_d = S_RD_NL;
        end
      end
      S_RD_NL: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc_q + 16'd2;
        if (bus.mem_ready) begin
          nn_d[7:0] = bus.mem_rdata;
          state_d   = S_RD_NH;
        end
      end
      S_RD_NH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc_q + 16'd3;
        if (bus.mem_ready) begin
          nn_d[15:8] = bus.mem_rdata;
          state_d    = S_WR_L;
        end
      end
      S_WR_L: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = nn_q;
        bus.mem_wdata = data_q[7:0];
        if (bus.mem_ready) state_d = S_WR_H;
      end
      S_WR_H: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = nn_q + 16'd1;
        bus.mem_wdata = data_q[15:8];
        if (bus.mem_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        pc_o    = pc_q + 16'd4;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef Z80FI_TRACE_EN
  assign trace_valid_o      = done_o;
  assign trace_insn_o       = {nn_q, 2'b01, dd_q, 4'b0011, 8'hED};
  assign trace_mem_waddr_o  = nn_q;
  assign trace_mem_waddr2_o = nn_q + 16'd1;
  assign trace_mem_wdata_o  = data_q[7:0];
  assign trace_mem_wdata2_o = data_q[15:8];
  assign trace_pc_rdata_o   = pc_q;
`endif

endmodule

// File: tb/tb_z80_seq_ld_extaddr_dd.sv
// tb/tb_z80_seq_ld_extaddr_dd.sv - directed vector bench for the LD (nn),dd sequencer
// Memory slave with programmable wait states; vector table plus corner sequences.
module tb_z80_seq_ld_extaddr_dd;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dd = 2'b00;
  logic [15:0] pc = 16'h0000;
  logic [3:0]  reg_rnum;
  logic [15:0] reg_rdata;
  logic        busy, done;
  logic [15:0] pc_out;
`ifdef Z80FI_TRACE_EN
  logic        tr_valid;
  logic [31:0] tr_insn;
  logic [15:0] tr_waddr, tr_waddr2, tr_pc;
  logic [7:0]  tr_wdata, tr_wdata2;
`endif

  z80_seq_ld_extaddr_dd_if bus();

  z80_seq_ld_extaddr_dd dut (
    .clk(clk), .rst(rst), .start_i(start), .dd_i(dd), .pc_i(pc),
    .reg_rnum_o(reg_rnum), .reg_rdata_i(reg_rdata), .bus(bus),
    .busy_o(busy), .done_o(done), .pc_o(pc_out)
`ifdef Z80FI_TRACE_EN
    , .trace_valid_o(tr_valid), .trace_insn_o(tr_insn),
    .trace_mem_waddr_o(tr_waddr), .trace_mem_waddr2_o(tr_waddr2),
    .trace_mem_wdata_o(tr_wdata), .trace_mem_wdata2_o(tr_wdata2),
    .trace_pc_rdata_o(tr_pc)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] regs [0:3];
  int          wait_n = 0;
  int          stall = 0;
  logic [15:0] ra_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          overlap = 0, strobe_cyc = 0, done_cnt = 0;
  int          total = 0, bad = 0;

  assign reg_rdata     = regs[reg_rnum[1:0]];
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = (bus.mem_rd || bus.mem_wr) && (stall == 0);

  always @(posedge clk) begin
    if (bus.mem_rd || bus.mem_wr) begin
      if (stall == 0) begin
        if (bus.mem_wr) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          wa_q.push_back(bus.mem_addr);
          wd_q.push_back(bus.mem_wdata);
        end else begin
          ra_q.push_back(bus.mem_addr);
        end
        stall <= wait_n;
      end else begin
        stall <= stall - 1;
      end
    end else begin
      stall <= wait_n;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_wr) overlap++;
    if (bus.mem_rd || bus.mem_wr) strobe_cyc++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  dd;
    logic [15:0] pc, rv, nn;
    int          w;
    logic [15:0] ra0, ra1, wa0, wa1;
    logic [7:0]  wd0, wd1;
    logic [15:0] pco;
    int          cyc;
    logic [31:0] insn;
  } vec_t;

  vec_t vt[5];

  task automatic start_insn(input logic [1:0] d, input logic [15:0] p);
    ra_q.delete(); wa_q.delete(); wd_q.delete();
    strobe_cyc = 0;
    done_cnt   = 0;
    start = 1'b1; dd = d; pc = p;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [15:0] a;
    logic        seen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) regs[i] = 16'h0000;

    //       dd     pc        rv        nn        w  ra0       ra1       wa0       wa1       wd0    wd1    pco       cyc insn
    vt[0] = '{2'd0, 16'h0100, 16'h1234, 16'h8000, 0, 16'h0102, 16'h0103, 16'h8000, 16'h8001, 8'h34, 8'h12, 16'h0104, 5,  32'h8000_43ED};
    vt[1] = '{2'd3, 16'h0200, 16'hBEEF, 16'h4000, 2, 16'h0202, 16'h0203, 16'h4000, 16'h4001, 8'hEF, 8'hBE, 16'h0204, 13, 32'h4000_73ED};
    vt[2] = '{2'd2, 16'h0300, 16'hA55A, 16'hFFFF, 0, 16'h0302, 16'h0303, 16'hFFFF, 16'h0000, 8'h5A, 8'hA5, 16'h0304, 5,  32'hFFFF_63ED};
    vt[3] = '{2'd0, 16'hFFFD, 16'h1234, 16'h1000, 0, 16'hFFFF, 16'h0000, 16'h1000, 16'h1001, 8'h34, 8'h12, 16'h0001, 5,  32'h1000_43ED};
    vt[4] = '{2'd1, 16'h1000, 16'hC0DE, 16'h2000, 1, 16'h1002, 16'h1003, 16'h2000, 16'h2001, 8'hDE, 8'hC0, 16'h1004, 9,  32'h2000_53ED};

    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd", bus.mem_rd, 1'b0);
    chk("rst_wr", bus.mem_wr, 1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 8'h00);
    chk("rst_pc_out", pc_out, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Vectors 3 and 4 run back to back: start is raised in the IDLE cycle after DONE.
    for (int i = 0; i < 5; i++) begin
      regs[vt[i].dd] = vt[i].rv;
      a = vt[i].pc + 16'd2; mem[a] = vt[i].nn[7:0];
      a = vt[i].pc + 16'd3; mem[a] = vt[i].nn[15:8];
      wait_n = vt[i].w;
      start_insn(vt[i].dd, vt[i].pc);
      cyc = 0;
      while (1) begin
        @(negedge clk);
        cyc++;
        if (done || cyc >= 200) break;
      end
      chk($sformatf("v%0d_latency", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d_pc_out", i), pc_out, vt[i].pco);
      chk($sformatf("v%0d_rnum", i), reg_rnum, {2'b10, vt[i].dd});
      chk($sformatf("v%0d_strobe_cyc", i), strobe_cyc, 4 * (vt[i].w + 1));
      chk($sformatf("v%0d_nrd", i), ra_q.size(), 2);
      chk($sformatf("v%0d_nwr", i), wa_q.size(), 2);
      chk($sformatf("v%0d_ra0", i), ra_q.size() > 0 ? ra_q[0] : 16'hxxxx, vt[i].ra0);
      chk($sformatf("v%0d_ra1", i), ra_q.size() > 1 ? ra_q[1] : 16'hxxxx, vt[i].ra1);
      chk($sformatf("v%0d_wa0", i), wa_q.size() > 0 ? wa_q[0] : 16'hxxxx, vt[i].wa0);
      chk($sformatf("v%0d_wa1", i), wa_q.size() > 1 ? wa_q[1] : 16'hxxxx, vt[i].wa1);
      chk($sformatf("v%0d_wd0", i), wd_q.size() > 0 ? wd_q[0] : 8'hxx, vt[i].wd0);
      chk($sformatf("v%0d_wd1", i), wd_q.size() > 1 ? wd_q[1] : 8'hxx, vt[i].wd1);
`ifdef Z80FI_TRACE_EN
      chk($sformatf("v%0d_tr_valid", i), tr_valid, 1'b1);
      chk($sformatf("v%0d_tr_insn", i), tr_insn, vt[i].insn);
      chk($sformatf("v%0d_tr_waddr", i), tr_waddr, vt[i].wa0);
      chk($sformatf("v%0d_tr_waddr2", i), tr_waddr2, vt[i].wa1);
      chk($sformatf("v%0d_tr_wdata", i), tr_wdata, vt[i].wd0);
      chk($sformatf("v%0d_tr_wdata2", i), tr_wdata2, vt[i].wd1);
      chk($sformatf("v%0d_tr_pc", i), tr_pc, vt[i].pc);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      chk($sformatf("v%0d_idle_done", i), done, 1'b0);
    end

    // Register change after start and a start pulse in RD_NH must both be ignored.
    regs[0] = 16'hABCD;
    mem[16'h0402] = 8'h00; mem[16'h0403] = 8'h30;
    wait_n = 0;
    start_insn(2'd0, 16'h0400);
    @(negedge clk);
    regs[0] = 16'h0000;
    @(negedge clk);
    start = 1'b1; dd = 2'd1; pc = 16'h5555;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_nrd", ra_q.size(), 2);
    chk("busy_start_nwr", wa_q.size(), 2);
    chk("capture_lo", mem[16'h3000], 8'hCD);
    chk("capture_hi", mem[16'h3001], 8'hAB);

    // Reset in WR_L: strobe drops asynchronously and nn+1 is never written.
    mem[16'h3000] = 8'h66; mem[16'h3001] = 8'h77;
    mem[16'h0502] = 8'h00; mem[16'h0503] = 8'h30;
    regs[2] = 16'h1122;
    start_insn(2'd2, 16'h0500);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.mem_wr) begin seen = 1'b1; break; end
    end
    chk("rst_mid_reached_wr_l", seen, 1'b1);
    chk("rst_mid_wr_addr", bus.mem_addr, 16'h3000);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", bus.mem_wr, 1'b0);
    chk("rst_mid_rd", bus.mem_rd, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_addr", bus.mem_addr, 16'h0000);
    chk("rst_mid_wdata", bus.mem_wdata, 8'h00);
    chk("rst_mid_pc_out", pc_out, 16'h0000);
    chk("rst_mid_rnum", reg_rnum, 4'hA);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_nwr", wa_q.size(), 0);
    chk("rst_mid_mem_lo", mem[16'h3000], 8'h66);
    chk("rst_mid_mem_hi", mem[16'h3001], 8'h77);
    chk("rst_mid_idle_busy", busy, 1'b0);

    chk("rd_wr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
